// File: rtl/sound_out_pkg.sv
// Shared types and constants for the sound output stage: FSM states, multiplier
// geometry and the stereo pair carried through the sample FIFO.
package sound_out_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StPush
    } out_state_e;

    // Volume is applied as m * (vol + 1) >> VOL_FRAC_SHIFT, one multiplier bit per step.
    localparam int unsigned VOL_FRAC_SHIFT = 3;
    localparam int unsigned MUL_STEPS      = 4;

    localparam int unsigned PAIR_SAMPLE_W = 20;

    typedef struct packed {
        logic [PAIR_SAMPLE_W-1:0] left;
        logic [PAIR_SAMPLE_W-1:0] right;
    } stereo_pair_t;

endpackage

// File: rtl/sound_sample_fifo.sv
// First-word fall-through FIFO for stereo sample pairs. The head output holds its
// last shown value while the FIFO is empty; a push into a full FIFO without a pop is dropped.
module sound_sample_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 40
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     drop_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_depth_check
        $error("sound_sample_fifo: Depth must be a power of 2 and at least 2");
    end

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic [Width-1:0] hold_q;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LvlW'(Depth));
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
            if (!empty) begin
                hold_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = empty ? hold_q : mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign full_o  = full;
    assign level_o = level_q;

endmodule

// File: rtl/sound_output_stage.sv
// Decimates the sound_controller SO1/SO2 mix to a fixed sample rate, applies NR50 volume
// with a 4-step shift-add multiply and queues stereo pairs for the AC97 slot formatter.
module sound_output_stage
    import sound_out_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 87,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SAMPLE_W   = PAIR_SAMPLE_W
) (
    input  logic                          I_CLK,
    input  logic                          I_RESET,
    input  logic [SAMPLE_W-1:0]           I_SO1,
    input  logic [SAMPLE_W-1:0]           I_SO2,
    input  logic [7:0]                    I_NR50,
    input  logic                          I_SOUND_EN,
    input  logic                          I_READY,
    input  logic                          I_CLR_FLAGS,
    output logic [SAMPLE_W-1:0]           O_SAMPLE_L,
    output logic [SAMPLE_W-1:0]           O_SAMPLE_R,
    output logic                          O_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   O_LEVEL,
    output logic                          O_OVERFLOW
);

    localparam int unsigned CntW = $clog2(SAMPLE_DIV);
    localparam int unsigned AccW = SAMPLE_W + VOL_FRAC_SHIFT;

    if (SAMPLE_DIV < 6) begin : gen_div_check
        $error("sound_output_stage: SAMPLE_DIV must be at least 6");
    end
    if (SAMPLE_W != PAIR_SAMPLE_W) begin : gen_width_check
        $error("sound_output_stage: SAMPLE_W must match the stereo pair width");
    end

    logic [CntW-1:0] cnt_q;
    logic            tick;

    out_state_e      state_q;
    logic [AccW-1:0] ml_q;
    logic [AccW-1:0] mr_q;
    logic [3:0]      vl_q;
    logic [3:0]      vr_q;
    logic [AccW-1:0] acc_l_q;
    logic [AccW-1:0] acc_r_q;
    logic [1:0]      step_q;

    logic            ovf_q;
    logic            fifo_push;
    logic            fifo_drop;
    logic            fifo_full;
    stereo_pair_t    push_pair;
    stereo_pair_t    head_pair;
    logic            unused_bits;

    assign tick = (cnt_q == CntW'(SAMPLE_DIV - 1));

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= StIdle;
            ml_q    <= '0;
            mr_q    <= '0;
            vl_q    <= '0;
            vr_q    <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            step_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        ml_q    <= I_SOUND_EN ? AccW'(I_SO2) : '0;
                        mr_q    <= I_SOUND_EN ? AccW'(I_SO1) : '0;
                        vl_q    <= {1'b0, I_NR50[6:4]} + 4'd1;
                        vr_q    <= {1'b0, I_NR50[2:0]} + 4'd1;
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        step_q  <= '0;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_l_q <= acc_l_q + (vl_q[step_q] ? (ml_q << step_q) : '0);
                    acc_r_q <= acc_r_q + (vr_q[step_q] ? (mr_q << step_q) : '0);
                    step_q  <= step_q + 1'b1;
                    if (step_q == 2'(MUL_STEPS - 1)) begin
                        state_q <= StPush;
                    end
                end
                StPush: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // m * 8 fits in AccW bits, so dropping the fraction never needs saturation.
    assign push_pair.left  = acc_l_q[AccW-1:VOL_FRAC_SHIFT];
    assign push_pair.right = acc_r_q[AccW-1:VOL_FRAC_SHIFT];
    assign fifo_push       = (state_q == StPush);

    sound_sample_fifo #(
        .Depth (FIFO_DEPTH),
        .Width ($bits(stereo_pair_t))
    ) u_fifo (
        .clk_i       (I_CLK),
        .rst_i       (I_RESET),
        .push_i      (fifo_push),
        .push_data_i (push_pair),
        .pop_i       (I_READY),
        .head_o      (head_pair),
        .valid_o     (O_VALID),
        .full_o      (fifo_full),
        .level_o     (O_LEVEL),
        .drop_o      (fifo_drop)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop) begin
            ovf_q <= 1'b1;
        end else if (I_CLR_FLAGS) begin
            ovf_q <= 1'b0;
        end
    end

    assign O_SAMPLE_L = head_pair.left;
    assign O_SAMPLE_R = head_pair.right;
    assign O_OVERFLOW = ovf_q;

    // Fractional product bits, the Vin enables and the full flag are not needed here.
    assign unused_bits = ^{acc_l_q[VOL_FRAC_SHIFT-1:0], acc_r_q[VOL_FRAC_SHIFT-1:0],
                           I_NR50[7], I_NR50[3], fifo_full};

endmodule

// File: tb/tb_sound_output_stage.sv
// Scoreboard bench for sound_output_stage: ticks queue hand-computed pairs, a negedge
// monitor compares each popped head against the queue in order.
module tb_sound_output_stage;

    localparam int unsigned DIV   = 87;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = 20;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] so1;
    logic [W-1:0] so2;
    logic [7:0]   nr50;
    logic         en;
    logic         rdy;
    logic         clr;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;
    logic         out_valid;
    logic [3:0]   out_level;
    logic         out_ovf;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks   = 0;
    int           failures = 0;
    int unsigned  tb_cnt   = 0;

    always #5 clk = ~clk;

    sound_output_stage #(
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH),
        .SAMPLE_W   (W)
    ) dut (
        .I_CLK       (clk),
        .I_RESET     (rst),
        .I_SO1       (so1),
        .I_SO2       (so2),
        .I_NR50      (nr50),
        .I_SOUND_EN  (en),
        .I_READY     (rdy),
        .I_CLR_FLAGS (clr),
        .O_SAMPLE_L  (out_l),
        .O_SAMPLE_R  (out_r),
        .O_VALID     (out_valid),
        .O_LEVEL     (out_level),
        .O_OVERFLOW  (out_ovf)
    );

    // Bench-side tick timing: the cycle in which this reads DIV-1 is a tick cycle.
    always @(posedge clk) begin
        if (rst) tb_cnt = 0;
        else if (tb_cnt == DIV - 1) tb_cnt = 0;
        else tb_cnt = tb_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got L=0x%0h R=0x%0h expected no sample",
                         out_l, out_r);
            end else begin
                mon_e = sb_q.pop_front();
                check("pop_left", 32'(out_l), 32'(mon_e.l));
                check("pop_right", 32'(out_r), 32'(mon_e.r));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the inputs, waits through the next tick cycle t and returns during t+1.
    task automatic issue(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [7:0] v,
                         input logic e, input bit push, input logic [W-1:0] exp_l,
                         input logic [W-1:0] exp_r);
        int n;
        exp_t x;
        so1  = s1;
        so2  = s2;
        nr50 = v;
        en   = e;
        n    = 0;
        while (tb_cnt != DIV - 1 && n < 2 * DIV) begin
            step();
            n++;
        end
        if (n >= 2 * DIV) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: got no tick in %0d cycles expected one", n);
        end
        x.l = exp_l;
        x.r = exp_r;
        if (push) sb_q.push_back(x);
        step();
    endtask

    logic [W-1:0] t4_so1 [10] = '{20'h00001, 20'h00010, 20'h00100, 20'h01000, 20'h10000,
                                  20'hFFFFF, 20'hABCDE, 20'h12345, 20'h55555, 20'hAAAAA};
    logic [W-1:0] t4_so2 [10] = '{20'hFFFFE, 20'hFFFEF, 20'hFFEFF, 20'hFEFFF, 20'hEFFFF,
                                  20'h00000, 20'h54321, 20'hEDCBA, 20'hAAAAA, 20'h55555};
    // NR50 = 0x31: left scaled by 4/8, right by 2/8.
    logic [W-1:0] t5_so1 [9]  = '{20'h00004, 20'h00400, 20'h40000, 20'hFFFFF, 20'h00003,
                                  20'h12344, 20'h0000C, 20'h80000, 20'h00100};
    logic [W-1:0] t5_r   [9]  = '{20'h00001, 20'h00100, 20'h10000, 20'h3FFFF, 20'h00000,
                                  20'h048D1, 20'h00003, 20'h20000, 20'h00040};
    logic [W-1:0] t5_so2 [9]  = '{20'h00002, 20'h00200, 20'h80000, 20'hFFFFF, 20'h00001,
                                  20'h24680, 20'h0000E, 20'h40000, 20'h00300};
    logic [W-1:0] t5_l   [9]  = '{20'h00001, 20'h00100, 20'h40000, 20'h7FFFF, 20'h00000,
                                  20'h12340, 20'h00007, 20'h20000, 20'h00180};

    initial begin
        rst  = 1'b1;
        so1  = '0;
        so2  = '0;
        nr50 = 8'h00;
        en   = 1'b0;
        rdy  = 1'b0;
        clr  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset, no tick within 50 cycles.
        repeat (50) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(out_level), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_left", 32'(out_l), 32'd0);
        check("rst_right", 32'(out_r), 32'd0);

        // Full volume is identity; valid rises exactly at t+6.
        rdy = 1'b1;
        issue(20'h80000, 20'h40000, 8'h77, 1'b1, 1'b1, 20'h40000, 20'h80000);
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("latency_valid_t%0d", i), 32'(out_valid), (i == 6) ? 32'd1 : 32'd0);
            if (i < 6) step();
        end
        step();
        check("after_pop_valid", 32'(out_valid), 32'd0);
        check("hold_left", 32'(out_l), 32'h40000);
        check("hold_right", 32'(out_r), 32'h80000);

        // Asymmetric volumes, then Vin-only NR50.
        issue(20'hFFFFF, 20'hFFFFF, 8'h03, 1'b1, 1'b1, 20'h1FFFF, 20'h7FFFF);
        issue(20'hFFFFF, 20'hFFFFF, 8'h88, 1'b1, 1'b1, 20'h1FFFF, 20'h1FFFF);
        repeat (8) step();

        // Fill with the consumer stalled: ticks 9 and 10 are dropped.
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue(t4_so1[i], t4_so2[i], 8'h77, 1'b1, i < 8, t4_so2[i], t4_so1[i]);
            if (i == 7) begin
                repeat (5) step();
                check("fill8_level", 32'(out_level), 32'd8);
                check("fill8_ovf", 32'(out_ovf), 32'd0);
            end else if (i == 8) begin
                repeat (5) step();
                check("drop_level", 32'(out_level), 32'd8);
                check("drop_ovf", 32'(out_ovf), 32'd1);
            end
        end
        repeat (6) step();
        rdy = 1'b1;
        repeat (10) step();
        check("drain_level", 32'(out_level), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(out_ovf), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovf_cleared", 32'(out_ovf), 32'd0);

        // Full FIFO with a pop on the very PUSH cycle: push accepted, no overflow.
        rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            issue(t5_so1[i], t5_so2[i], 8'h31, 1'b1, 1'b1, t5_l[i], t5_r[i]);
        end
        repeat (4) step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("pushpop_level", 32'(out_level), 32'd8);
        check("pushpop_ovf", 32'(out_ovf), 32'd0);
        rdy = 1'b1;
        repeat (12) step();
        check("pushpop_drain", 32'(out_level), 32'd0);

        // Reset mid-multiply flushes the FIFO and discards the sample in flight.
        rdy = 1'b0;
        issue(20'h11111, 20'h22222, 8'h77, 1'b1, 1'b0, 20'h0, 20'h0);
        repeat (5) step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_level", 32'(out_level), 32'd1);
        issue(20'h33333, 20'h44444, 8'h77, 1'b1, 1'b0, 20'h0, 20'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", 32'(out_level), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_left", 32'(out_l), 32'd0);
        for (int i = 4; i <= 7; i++) begin
            step();
            check($sformatf("no_sample_t%0d", i), 32'(out_valid), 32'd0);
        end

        // Sound disabled: zero pairs keep the cadence.
        rdy = 1'b1;
        issue(20'h12345, 20'h54321, 8'h77, 1'b0, 1'b1, 20'h0, 20'h0);
        issue(20'hFFFFF, 20'hFFFFF, 8'h77, 1'b0, 1'b1, 20'h0, 20'h0);
        repeat (8) step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_output_stage.md
Name: sound_output_stage

Overview:
- Sits directly downstream of sound_controller. Consumes its 20-bit SO1/SO2 mix and NR50 master volume, which sound_controller leaves unapplied.
- Decimates the mix to a fixed output sample rate and applies per-terminal NR50 volume using a sequential shift-add multiplier.
- Buffers stereo sample pairs in a small FIFO and presents them through a valid/ready handshake to the AC97 slot formatter, all in the same clock domain.

Parameters:
- SAMPLE_DIV, 87: I_CLK cycles per output sample (4.194304 MHz / 48 kHz). Must be >= 6; elaboration error otherwise.
- FIFO_DEPTH, 8: stereo pairs buffered. Must be a power of 2, >= 2.
- SAMPLE_W, 20: sample width in bits.

Ports:
- I_CLK  in  1  system clock.
- I_RESET  in  1  reset, synchronous, active-high.
- I_SO1  in  SAMPLE_W  unsigned right-terminal mix from sound_controller.
- I_SO2  in  SAMPLE_W  unsigned left-terminal mix from sound_controller.
- I_NR50  in  8  NR50 register value. [6:4] = SO2 volume, [2:0] = SO1 volume; bits 7 and 3 (Vin) are ignored.
- I_SOUND_EN  in  1  NR52[7]. When 0, samples are forced to 0.
- I_READY  in  1  consumer accepts the head sample this cycle.
- I_CLR_FLAGS  in  1  clears the sticky overflow flag.
- O_SAMPLE_L  out  SAMPLE_W  head-of-FIFO left sample (scaled SO2).
- O_SAMPLE_R  out  SAMPLE_W  head-of-FIFO right sample (scaled SO1).
- O_VALID  out  1  FIFO not empty.
- O_LEVEL  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- O_OVERFLOW  out  1  sticky; set when a sample pair is dropped because the FIFO is full.

Behaviour:
- Reset, applied on any cycle:
  - tick counter = 0, FSM = IDLE, FIFO empty, O_LEVEL = 0, O_VALID = 0, O_SAMPLE_L/R = 0, O_OVERFLOW = 0.
  - Any in-progress multiply is discarded and nothing is pushed.
- Tick counter:
  - Free-running from 0 to SAMPLE_DIV-1, then wraps to 0.
  - tick = 1 on the cycle the counter equals SAMPLE_DIV-1.
  - The counter runs independently of FSM state.
- FSM states: IDLE, MUL, PUSH.
  - IDLE:
    - On tick (cycle t), latch ml = I_SO2 and mr = I_SO1, or 0 for both if I_SOUND_EN = 0.
    - Latch multipliers vl = I_NR50[6:4]+1 and vr = I_NR50[2:0]+1 (4-bit, range 1..8).
    - Clear both accumulators; go to MUL.
  - MUL:
    - Four cycles (t+1..t+4), bit index k = 0..3.
    - acc_x += (v_x[k] ? m_x << k : 0), with accumulators SAMPLE_W+3 bits wide.
    - After k = 3, go to PUSH.
  - PUSH (t+5):
    - Write pair {acc_l[SAMPLE_W+2:3], acc_r[SAMPLE_W+2:3]}, i.e. result = (m*(vol+1)) >> 3, truncating.
    - The result never exceeds 2^SAMPLE_W-1; no saturation logic is needed.
    - Return to IDLE.
  - Ticks arriving outside IDLE cannot occur, because SAMPLE_DIV >= 6.
- NR50 and I_SOUND_EN are sampled only at the IDLE tick. Changes mid-multiply take effect on the next sample.
- FIFO:
  - First-word fall-through. O_SAMPLE_L/R show the head whenever O_VALID = 1 and hold their last value otherwise.
  - Pop when O_VALID && I_READY.
  - Push in PUSH is accepted if not full, or if full and a pop occurs in the same cycle. In that case O_LEVEL is unchanged.
  - Push is dropped if full and no pop occurs. The FIFO contents are unchanged and O_OVERFLOW is set the next cycle.
  - A simultaneous push and pop on an empty FIFO cannot occur, since O_VALID = 0 blocks the pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a tick at cycle t with the FIFO previously empty gives O_VALID = 1 at t+6.
- I_CLR_FLAGS clears O_OVERFLOW next cycle. If a drop occurs in the same cycle, set wins.
- A new sample pair is produced every SAMPLE_DIV cycles, including while I_SOUND_EN = 0 (zero samples), so the AC97 cadence is preserved.

Decomposition:
- Package sound_out_pkg holds:
  - the FSM state enum {IDLE, MUL, PUSH};
  - VOL_FRAC_SHIFT = 3;
  - MUL_STEPS = 4;
  - the stereo pair struct {left, right}.
- One sub-module: sound_sample_fifo (parameterised depth and width, FWFT, push/pop/full/empty/level).
- The tick counter, FSM and multiplier stay in the top module.

Test Plan:
- Reset, then hold I_READY = 0 for 50 cycles with no tick -> O_VALID = 0, O_LEVEL = 0, O_OVERFLOW = 0, O_SAMPLE_L/R = 0.
- I_SO1 = 0x80000, I_SO2 = 0x40000, I_NR50 = 0x77, I_SOUND_EN = 1, I_READY = 1 -> O_VALID rises exactly 6 cycles after tick with L = 0x40000, R = 0x80000, then a pop.
- I_SO1 = I_SO2 = 0xFFFFF, I_NR50 = 0x03 -> R = 0x7FFFF, L = 0x1FFFF; with I_NR50 = 0x88 (Vin bits only) -> both = 0x1FFFF.
- I_READY = 0 for 10 ticks with distinct inputs each tick -> O_LEVEL = 8 and O_OVERFLOW = 1 after tick 9. Then raising I_READY pops ticks 1..8 in order. Then I_CLR_FLAGS -> O_OVERFLOW = 0.
- FIFO full, with I_READY = 1 asserted exactly on the PUSH cycle -> push accepted, O_LEVEL stays 8, no overflow.
- Assert I_RESET during MUL (t+2) -> the next cycle is IDLE, O_LEVEL = 0, O_VALID = 0, and no sample appears at t+6.
- I_SOUND_EN = 0 with non-zero inputs -> a zero pair is pushed on every tick.
